// File: rtl/ocimem_debug_ram_ctrl.sv
// OCI debug memory controller: decodes JTAG debug memory commands into MonAReg/MonDReg
// and shares a single-port debug RAM with an Avalon-MM CPU slave, debug side first.
module ocimem_debug_ram_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic              dbg_rd_pend;
    logic              cpu_rd_pend;

    logic              dbg_cmd;
    logic              sel_b;
    logic              sel_a;
    logic              sel_na;

    logic              ram_rd;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              dbg_rd;
    logic              cpu_rd;
    logic [ADDR_W-1:0] mon_a_next;

    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign dbg_cmd = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign sel_b   = take_action_ocimem_b;
    assign sel_a   = take_action_ocimem_a & ~take_action_ocimem_b;
    assign sel_na  = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    // One RAM access per cycle: debug command, else CPU write, else CPU read.
    always_comb begin
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = MonAReg;
        ram_wdata  = jdo[34:3];
        ram_be     = 4'hf;
        dbg_rd     = 1'b0;
        cpu_rd     = 1'b0;
        mon_a_next = MonAReg;
        if (reset) begin
            ram_rd = 1'b0;
        end else if (sel_b) begin
            ram_wr     = 1'b1;
            mon_a_next = MonAReg + 1'b1;
        end else if (sel_a) begin
            if (jdo[35]) begin
                mon_a_next = jdo[ADDR_W+25:26];
            end
            if (jdo[25]) begin
                ram_rd   = 1'b1;
                dbg_rd   = 1'b1;
                ram_addr = mon_a_next;
            end
        end else if (sel_na) begin
            ram_rd     = 1'b1;
            dbg_rd     = 1'b1;
            mon_a_next = MonAReg + 1'b1;
        end else if (avs_write) begin
            ram_wr    = 1'b1;
            ram_addr  = avs_address;
            ram_wdata = avs_writedata;
            ram_be    = avs_byteenable;
        end else if (avs_read && !cpu_rd_pend) begin
            ram_rd   = 1'b1;
            cpu_rd   = 1'b1;
            ram_addr = avs_address;
        end
    end

    // RAM array has no reset so its contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
        if (ram_rd) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            dbg_rd_pend   <= 1'b0;
            cpu_rd_pend   <= 1'b0;
        end else begin
            MonAReg       <= mon_a_next;
            monitor_ready <= dbg_rd_pend;
            dbg_rd_pend   <= dbg_rd;
            cpu_rd_pend   <= cpu_rd;
            // A debug write landing on a pending read's return slot is the newer value.
            if (sel_b) begin
                MonDReg <= jdo[34:3];
            end else if (dbg_rd_pend) begin
                MonDReg <= ram_q;
            end
        end
    end

    assign avs_readdata    = (cpu_rd_pend && !reset) ? ram_q : 32'h0;
    assign avs_waitrequest = reset | dbg_cmd | (avs_read & ~avs_write & ~cpu_rd_pend);

endmodule

// File: tb/tb_ocimem_debug_ram_ctrl.sv
// Self-checking bench for ocimem_debug_ram_ctrl: debug commands, CPU port, arbitration, reset.
module tb_ocimem_debug_ram_ctrl;
    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        monitor_ready;

    int checks;
    int failures;
    int ready_cnt;

    logic [31:0] dbg_exp_q[$];
    logic [31:0] cpu_exp_q[$];
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_a;

    ocimem_debug_ram_ctrl #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: compares debug and CPU read returns against the expected queues.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (monitor_ready === 1'b1) begin
            ready_cnt++;
            checks++;
            if (dbg_exp_q.size() == 0) begin
                failures++;
                $display("FAIL monitor_ready_unexpected MonDReg=%h", MonDReg);
            end else begin
                exp = dbg_exp_q.pop_front();
                if (MonDReg !== exp) begin
                    failures++;
                    $display("FAIL dbg_read_data got=%h exp=%h", MonDReg, exp);
                end
            end
        end
        if (avs_read === 1'b1 && avs_write === 1'b0 && avs_waitrequest === 1'b0) begin
            checks++;
            if (cpu_exp_q.size() == 0) begin
                failures++;
                $display("FAIL cpu_read_unexpected readdata=%h", avs_readdata);
            end else begin
                exp = cpu_exp_q.pop_front();
                if (avs_readdata !== exp) begin
                    failures++;
                    $display("FAIL cpu_read_data got=%h exp=%h", avs_readdata, exp);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic dbg_action_a(input logic load, input logic [7:0] addr, input logic rd);
        jdo = '0;
        jdo[35] = load;
        jdo[33:26] = addr;
        jdo[25] = rd;
        if (load) ref_a = addr;
        if (rd) dbg_exp_q.push_back(ref_mem[ref_a]);
        take_action_ocimem_a = 1'b1;
        next_cycle();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic dbg_no_action_a(input logic expect_data);
        if (expect_data) dbg_exp_q.push_back(ref_mem[ref_a]);
        ref_a = ref_a + 8'd1;
        take_no_action_ocimem_a = 1'b1;
        next_cycle();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic dbg_write_b(input logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        ref_mem[ref_a] = data;
        ref_a = ref_a + 8'd1;
        take_action_ocimem_b = 1'b1;
        next_cycle();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) ref_mem[addr][8*i +: 8] = data[8*i +: 8];
        end
        avs_address = addr;
        avs_writedata = data;
        avs_byteenable = be;
        avs_write = 1'b1;
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL cpu_write_wait got=%b exp=0", avs_waitrequest);
        end
        next_cycle();
        avs_write = 1'b0;
    endtask

    // Holds avs_read until accepted; returns the number of stalled cycles.
    task automatic cpu_read(input logic [7:0] addr, output int waits);
        bit done;
        waits = 0;
        done = 1'b0;
        cpu_exp_q.push_back(ref_mem[addr]);
        avs_address = addr;
        avs_read = 1'b1;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (avs_waitrequest === 1'b1) waits++;
            else done = 1'b1;
            next_cycle();
            take_no_action_ocimem_a = 1'b0;
        end
        avs_read = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL cpu_read_timeout waits=%0d exp=<10", waits);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            failures++;
            $display("FAIL reset_waitrequest got=%b exp=1", avs_waitrequest);
        end
        next_cycle();
        reset = 1'b0;
        ref_a = 8'h00;
        @(negedge clk);
        checks++;
        if (MonAReg !== 8'h00 || MonDReg !== 32'h0 || monitor_ready !== 1'b0 ||
            avs_readdata !== 32'h0 || avs_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got=%h/%h/%b/%h/%b exp=00/00000000/0/00000000/0",
                     MonAReg, MonDReg, monitor_ready, avs_readdata, avs_waitrequest);
        end
        next_cycle();
    endtask

    task automatic test_addr_load();
        int rc;
        rc = ready_cnt;
        dbg_action_a(1'b1, 8'h10, 1'b0);
        idle(3);
        checks++;
        if (MonAReg !== 8'h10) begin
            failures++;
            $display("FAIL addr_load got=%h exp=10", MonAReg);
        end
        checks++;
        if (ready_cnt != rc) begin
            failures++;
            $display("FAIL addr_load_no_ready got=%0d exp=%0d", ready_cnt, rc);
        end
    endtask

    task automatic test_write_wrap();
        dbg_action_a(1'b1, 8'hFE, 1'b0);
        dbg_write_b(32'hA5A50001);
        dbg_write_b(32'hA5A50002);
        dbg_write_b(32'hA5A50003);
        @(negedge clk);
        checks++;
        if (MonAReg !== 8'h01 || MonDReg !== 32'hA5A50003) begin
            failures++;
            $display("FAIL write_wrap got=%h/%h exp=01/a5a50003", MonAReg, MonDReg);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0] pattern;
        dbg_action_a(1'b1, 8'hFE, 1'b0);
        dbg_no_action_a(1'b1);
        dbg_no_action_a(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pattern[2-i] = monitor_ready;
            if (i == 0) begin
                checks++;
                if (MonAReg !== 8'h00) begin
                    failures++;
                    $display("FAIL b2b_addr_wrap got=%h exp=00", MonAReg);
                end
            end
            next_cycle();
        end
        checks++;
        if (pattern !== 3'b110) begin
            failures++;
            $display("FAIL b2b_ready_pattern got=%b exp=110", pattern);
        end
        dbg_action_a(1'b1, 8'h00, 1'b1);
        idle(3);
        checks++;
        if (MonAReg !== 8'h00) begin
            failures++;
            $display("FAIL load_read_addr got=%h exp=00", MonAReg);
        end
    endtask

    task automatic test_cpu_write_read();
        int waits;
        cpu_write(8'h20, 32'hDEADBEEF, 4'b1111);
        cpu_write(8'h20, 32'h12345678, 4'b0011);
        checks++;
        if (ref_mem[8'h20] !== 32'hDEAD5678) begin
            failures++;
            $display("FAIL ref_partial got=%h exp=dead5678", ref_mem[8'h20]);
        end
        cpu_read(8'h20, waits);
        checks++;
        if (waits != 1) begin
            failures++;
            $display("FAIL cpu_read_waits got=%0d exp=1", waits);
        end
    endtask

    task automatic test_collision();
        int waits;
        dbg_action_a(1'b1, 8'hFF, 1'b0);
        dbg_exp_q.push_back(ref_mem[ref_a]);
        ref_a = ref_a + 8'd1;
        take_no_action_ocimem_a = 1'b1;
        cpu_read(8'h20, waits);
        checks++;
        if (waits != 2) begin
            failures++;
            $display("FAIL collision_waits got=%0d exp=2", waits);
        end
        idle(3);
    endtask

    task automatic test_random_cpu();
        int waits;
        logic [7:0] addr;
        for (int i = 0; i < 8; i++) begin
            addr = 8'($urandom_range(64, 127));
            cpu_write(addr, $urandom, 4'hf);
            cpu_write(addr, $urandom, 4'($urandom_range(0, 15)));
            cpu_read(addr, waits);
        end
    endtask

    task automatic test_reset_mid();
        int rc;
        int waits;
        rc = ready_cnt;
        dbg_action_a(1'b1, 8'hFE, 1'b0);
        dbg_no_action_a(1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        ref_a = 8'h00;
        idle(3);
        checks++;
        if (ready_cnt != rc) begin
            failures++;
            $display("FAIL reset_mid_ready got=%0d exp=%0d", ready_cnt, rc);
        end
        checks++;
        if (MonAReg !== 8'h00 || MonDReg !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_regs got=%h/%h exp=00/00000000", MonAReg, MonDReg);
        end
        dbg_no_action_a(1'b1);
        idle(3);
        cpu_read(8'hFE, waits);
        idle(2);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ready_cnt = 0;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        ref_a = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;

        test_reset();
        test_addr_load();
        test_write_wrap();
        test_back_to_back();
        test_cpu_write_read();
        test_collision();
        test_random_cpu();
        test_reset_mid();

        checks++;
        if (dbg_exp_q.size() != 0 || cpu_exp_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained got=%0d/%0d exp=0/0", dbg_exp_q.size(), cpu_exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
